// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm ring/snooze controller.
// Time values are plain binary hours/minutes/seconds.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2,
        LOCKOUT = 2'd3
    } alarm_state_t;

    localparam int TIME_W  = 8;
    localparam int HRS_MAX = 23;
    localparam int MIN_MAX = 59;

    // Alarm fires at the top of the stored minute; 00:00 is legal.
    function automatic logic time_match(
        input logic [TIME_W-1:0] h,
        input logic [TIME_W-1:0] m,
        input logic [TIME_W-1:0] s,
        input logic [TIME_W-1:0] ah,
        input logic [TIME_W-1:0] am
    );
        return (h == ah) && (m == am) && (s == '0);
    endfunction

endpackage

// File: rtl/sec_down_counter.sv
// Seconds countdown shared by the ringing and snooze phases.
// Reloaded on every phase entry; holds at zero instead of wrapping.
module sec_down_counter #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic             zero
);

    logic [CNT_W-1:0] value;

    // Load has priority; decrement only while nonzero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (tick && (value != '0)) begin
            value <= value - 1'b1;
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/alarm_snooze_ctrl.sv
// Registered alarm FSM: ring, snooze (limited count), stop and lockout.
// Drives alarm_active and a 2 Hz buzzer toggle while ringing.
module alarm_snooze_ctrl
    import alarm_pkg::*;
#(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 540,
    parameter int MAX_SNOOZE  = 3,
    parameter int CNT_W       = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tick_1hz,
    input  logic              tick_2hz,
    input  logic [TIME_W-1:0] hrs,
    input  logic [TIME_W-1:0] min,
    input  logic [TIME_W-1:0] sec,
    input  logic [TIME_W-1:0] alm_hrs,
    input  logic [TIME_W-1:0] alm_min,
    input  logic              alarm_en,
    input  logic              snooze_btn,
    input  logic              stop_btn,
    output logic              alarm_active,
    output logic              buzzer,
    output logic [1:0]        snooze_cnt,
    output alarm_state_t      state
);

    localparam logic [CNT_W-1:0] RING_LD   = CNT_W'(RING_SECS - 1);
    localparam logic [CNT_W-1:0] SNOOZE_LD = CNT_W'(SNOOZE_SECS - 1);
    localparam logic [1:0]       SNZ_MAX   = 2'(MAX_SNOOZE);

    logic             snz_q;
    logic             stp_q;
    logic             snz_edge;
    logic             stp_edge;
    logic             match;
    logic             snz_ok;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_tick;
    logic             cnt_zero;

    assign snz_edge = snooze_btn & ~snz_q;
    assign stp_edge = stop_btn & ~stp_q;
    assign match    = time_match(hrs, min, sec, alm_hrs, alm_min);
    assign snz_ok   = snz_edge && (snooze_cnt < SNZ_MAX);

    // Countdown control: reload on phase entry, else count seconds.
    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = RING_LD;
        cnt_tick = 1'b0;
        if (alarm_en) begin
            unique case (state)
                IDLE: begin
                    cnt_load = tick_1hz && match;
                end
                RINGING: begin
                    if (stp_edge) begin
                        cnt_load = 1'b0;
                    end else if (snz_ok) begin
                        cnt_load = 1'b1;
                        cnt_val  = SNOOZE_LD;
                    end else begin
                        cnt_tick = tick_1hz;
                    end
                end
                SNOOZE: begin
                    if (stp_edge) begin
                        cnt_load = 1'b0;
                    end else if (tick_1hz && cnt_zero) begin
                        cnt_load = 1'b1;
                    end else begin
                        cnt_tick = tick_1hz;
                    end
                end
                default: begin
                    cnt_load = 1'b0;
                end
            endcase
        end
    end

    sec_down_counter #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .tick     (cnt_tick),
        .zero     (cnt_zero)
    );

    // Edge registers, state and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snz_q        <= 1'b0;
            stp_q        <= 1'b0;
            state        <= IDLE;
            buzzer       <= 1'b0;
            alarm_active <= 1'b0;
            snooze_cnt   <= 2'd0;
        end else begin
            snz_q <= snooze_btn;
            stp_q <= stop_btn;
            if (!alarm_en) begin
                state        <= IDLE;
                buzzer       <= 1'b0;
                alarm_active <= 1'b0;
                snooze_cnt   <= 2'd0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (tick_1hz && match) begin
                            state        <= RINGING;
                            snooze_cnt   <= 2'd0;
                            buzzer       <= 1'b0;
                            alarm_active <= 1'b1;
                        end
                    end
                    RINGING: begin
                        if (stp_edge) begin
                            state        <= LOCKOUT;
                            buzzer       <= 1'b0;
                            alarm_active <= 1'b0;
                        end else if (snz_ok) begin
                            state      <= SNOOZE;
                            snooze_cnt <= snooze_cnt + 2'd1;
                            buzzer     <= 1'b0;
                        end else if (tick_1hz && cnt_zero) begin
                            state        <= LOCKOUT;
                            buzzer       <= 1'b0;
                            alarm_active <= 1'b0;
                        end else if (tick_2hz) begin
                            buzzer <= ~buzzer;
                        end
                    end
                    SNOOZE: begin
                        if (stp_edge) begin
                            state        <= LOCKOUT;
                            alarm_active <= 1'b0;
                        end else if (tick_1hz && cnt_zero) begin
                            state  <= RINGING;
                            buzzer <= 1'b0;
                        end
                    end
                    default: begin
                        if (min != alm_min) begin
                            state <= IDLE;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alarm_snooze_ctrl.sv
// Randomised bench for alarm_snooze_ctrl with a scoreboard queue
// fed by a seconds-based reference model of the alarm life-cycle.
module tb_alarm_snooze_ctrl;
    import alarm_pkg::*;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         tick_1hz = 1'b0;
    logic         tick_2hz = 1'b0;
    logic [7:0]   hrs = '0, min = '0, sec = '0;
    logic [7:0]   alm_hrs = '0, alm_min = '0;
    logic         alarm_en = 1'b0;
    logic         snooze_btn = 1'b0;
    logic         stop_btn = 1'b0;
    logic         alarm_active;
    logic         buzzer;
    logic [1:0]   snooze_cnt;
    alarm_state_t state;

    always #5 clk = ~clk;

    alarm_snooze_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .tick_1hz     (tick_1hz),
        .tick_2hz     (tick_2hz),
        .hrs          (hrs),
        .min          (min),
        .sec          (sec),
        .alm_hrs      (alm_hrs),
        .alm_min      (alm_min),
        .alarm_en     (alarm_en),
        .snooze_btn   (snooze_btn),
        .stop_btn     (stop_btn),
        .alarm_active (alarm_active),
        .buzzer       (buzzer),
        .snooze_cnt   (snooze_cnt),
        .state        (state)
    );

    int         checks = 0;
    int         errors = 0;
    logic [5:0] exp_q[$];
    logic [5:0] mon_exp;
    logic [5:0] mon_got;

    // Reference model: phase, whole seconds left in phase, snoozes used.
    alarm_state_t m_st;
    int           m_left;
    int           m_snoozes;
    bit           m_buz;
    bit           m_psnz;
    bit           m_pstp;

    int th, tm, ts;
    int snz_hold, stp_hold;

    task automatic model_reset();
        m_st      = IDLE;
        m_left    = 0;
        m_snoozes = 0;
        m_buz     = 1'b0;
        m_psnz    = 1'b0;
        m_pstp    = 1'b0;
    endtask

    function automatic logic [5:0] model_out();
        logic       act;
        logic [1:0] c;
        act = (m_st == RINGING) || (m_st == SNOOZE);
        c   = 2'(m_snoozes);
        return {act, m_buz, c, 2'(m_st)};
    endfunction

    task automatic model_step();
        bit sn, sp, hit;
        sn  = snooze_btn && !m_psnz;
        sp  = stop_btn && !m_pstp;
        hit = (int'(hrs) == int'(alm_hrs)) && (int'(min) == int'(alm_min))
              && (sec == 8'd0);
        m_psnz = snooze_btn;
        m_pstp = stop_btn;
        if (!alarm_en) begin
            m_st      = IDLE;
            m_snoozes = 0;
            m_buz     = 1'b0;
        end else if (m_st == IDLE) begin
            if (tick_1hz && hit) begin
                m_st      = RINGING;
                m_left    = 60;
                m_snoozes = 0;
                m_buz     = 1'b0;
            end
        end else if (m_st == RINGING) begin
            if (sp) begin
                m_st  = LOCKOUT;
                m_buz = 1'b0;
            end else if (sn && m_snoozes < 3) begin
                m_st      = SNOOZE;
                m_left    = 540;
                m_snoozes = m_snoozes + 1;
                m_buz     = 1'b0;
            end else begin
                if (tick_2hz) m_buz = !m_buz;
                if (tick_1hz) begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_st  = LOCKOUT;
                        m_buz = 1'b0;
                    end
                end
            end
        end else if (m_st == SNOOZE) begin
            if (sp) begin
                m_st = LOCKOUT;
            end else if (tick_1hz) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_st   = RINGING;
                    m_left = 60;
                    m_buz  = 1'b0;
                end
            end
        end else begin
            if (min != alm_min) m_st = IDLE;
        end
    endtask

    task automatic advance_time();
        ts = ts + 1;
        if (ts > MIN_MAX) begin ts = 0; tm = tm + 1; end
        if (tm > MIN_MAX) begin tm = 0; th = th + 1; end
        if (th > HRS_MAX) th = 0;
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({alarm_active, buzzer, snooze_cnt, state} !== 6'b0) begin
            errors++;
            $display("FAIL %s got=%b want=000000", name,
                     {alarm_active, buzzer, snooze_cnt, state});
        end
    endtask

    // One episode: alarm at ah:am, clock starting 5 s before it.
    task automatic run_episode(input int ah, input int am, input int n,
                               input int p_snz, input int p_stp,
                               input bit both, input int en_off);
        int t0;
        t0 = (ah * 3600 + am * 60 - 5 + 86400) % 86400;
        th = t0 / 3600;
        tm = (t0 / 60) % 60;
        ts = t0 % 60;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tick_1hz = ($urandom % 2) == 0;
            tick_2hz = ($urandom % 2) == 0;
            if (tick_1hz) advance_time();
            hrs     = 8'(th);
            min     = 8'(tm);
            sec     = 8'(ts);
            alm_hrs = 8'(ah);
            alm_min = 8'(am);
            alarm_en = !(en_off > 0 && i >= en_off && i < en_off + 3);
            if (snz_hold > 0) begin
                snz_hold--;
                snooze_btn = 1'b1;
            end else begin
                snooze_btn = 1'b0;
                if (int'($urandom % 1000) < p_snz) begin
                    snz_hold = int'($urandom_range(1, 5));
                    if (both) stp_hold = snz_hold;
                end
            end
            if (stp_hold > 0) begin
                stp_hold--;
                stop_btn = 1'b1;
            end else begin
                stop_btn = 1'b0;
                if (int'($urandom % 1000) < p_stp)
                    stp_hold = int'($urandom_range(1, 5));
            end
            if (both && snz_hold > 0 && !snooze_btn) stop_btn = 1'b0;
            model_step();
            exp_q.push_back(model_out());
        end
    endtask

    // Monitor: compare DUT outputs after every edge against the queue.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_got = {alarm_active, buzzer, snooze_cnt, state};
            checks++;
            if (mon_got !== mon_exp) begin
                errors++;
                $display("FAIL outputs t=%0t got=%b want=%b (act,buz,cnt,st)",
                         $time, mon_got, mon_exp);
            end
        end
    end

    initial begin
        model_reset();
        snz_hold = 0;
        stp_hold = 0;
        repeat (3) @(posedge clk);
        #2;
        check_zero("reset_state");
        @(negedge clk);
        reset_n = 1'b1;

        run_episode(7, 30, 800, 0, 0, 1'b0, 0);
        run_episode(7, 30, 5000, 25, 0, 1'b0, 0);
        run_episode(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)),
                    600, 30, 0, 1'b1, 0);
        run_episode(6, 15, 1500, 60, 0, 1'b0, 300);
        run_episode(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)),
                    3000, 10, 3, 1'b0, 0);
        run_episode(12, 0, 40, 0, 0, 1'b0, 0);

        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check_zero("async_reset");
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;

        run_episode(0, 0, 400, 0, 0, 1'b0, 0);

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d want=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
